// File: rtl/mem_pkg.sv
// Shared encodings for the unified-memory arbiter: burst sizes, rw codes, FSM states, owner ids.
package mem_pkg;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    F_XFER,
    D_XFER,
    F_DRAIN,
    D_DRAIN
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic logic [4:0] size_to_beats(input logic [1:0] size);
    logic [4:0] beats;
    beats = 5'd1;
    case (size)
      SIZE_1:  beats = 5'd1;
      SIZE_4:  beats = 5'd4;
      SIZE_8:  beats = 5'd8;
      SIZE_16: beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: fixed D-over-F priority, or round-robin on last owner
// when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
  input  owner_e last_owner,
  output owner_e winner
);

  always_comb begin
    winner = OWN_D;
    if (f_req && !d_req) begin
      winner = OWN_F;
    end else if (f_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (last_owner == OWN_D) ? OWN_F : OWN_D;
`else
      winner = OWN_D;
`endif
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and 1/4/8/16-word burst sequencer for the unified memory port.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (round-robin) or fixed D-over-F when undefined.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [address_width-1:0] f_addr,
  input  logic [1:0]               f_size,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [data_width-1:0]    f_rdata,
  output logic                     f_done,
  input  logic                     d_req,
  input  logic [address_width-1:0] d_addr,
  input  logic [1:0]               d_size,
  input  logic                     d_rw,
  input  logic [data_width-1:0]    d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [data_width-1:0]    d_rdata,
  output logic                     d_done,
  output logic                     d_wready,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_data_in,
  output logic [1:0]               mem_access_size,
  output logic                     mem_rw,
  output logic                     mem_enable,
  input  logic                     mem_busy,
  input  logic [data_width-1:0]    mem_data_out
);

  localparam logic [address_width-1:0] ADDR_STEP = address_width'(4);

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic                     rw_q, rw_d;
  owner_e                   last_owner_q, last_owner_d;
  owner_e                   winner;

  mem_arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      rw_q         <= RW_READ;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Outputs are decoded combinationally and forced low while reset is held.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    rw_d            = rw_q;
    last_owner_d    = last_owner_q;
    f_gnt           = 1'b0;
    f_rvalid        = 1'b0;
    f_rdata         = '0;
    f_done          = 1'b0;
    d_gnt           = 1'b0;
    d_rvalid        = 1'b0;
    d_rdata         = '0;
    d_done          = 1'b0;
    d_wready        = 1'b0;
    mem_address     = '0;
    mem_data_in     = '0;
    mem_access_size = 2'b00;
    mem_rw          = 1'b0;
    mem_enable      = 1'b0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (!mem_busy && (f_req || d_req)) begin
            mem_enable   = 1'b1;
            last_owner_d = winner;
            if (winner == OWN_D) begin
              d_gnt           = 1'b1;
              mem_address     = d_addr;
              mem_access_size = d_size;
              mem_rw          = d_rw;
              rw_d            = d_rw;
              addr_d          = d_addr + ADDR_STEP;
              cnt_d           = 4'(size_to_beats(d_size) - 5'd1);
              if (d_rw == RW_WRITE) begin
                mem_data_in = d_wdata;
                d_wready    = 1'b1;
                if (cnt_d == 4'd0) d_done = 1'b1;
                else               state_d = D_XFER;
              end else begin
                state_d = (cnt_d == 4'd0) ? D_DRAIN : D_XFER;
              end
            end else begin
              f_gnt           = 1'b1;
              mem_address     = f_addr;
              mem_access_size = f_size;
              mem_rw          = RW_READ;
              rw_d            = RW_READ;
              addr_d          = f_addr + ADDR_STEP;
              cnt_d           = 4'(size_to_beats(f_size) - 5'd1);
              state_d         = (cnt_d == 4'd0) ? F_DRAIN : F_XFER;
            end
          end
        end
        F_XFER: begin
          f_rvalid    = 1'b1;
          f_rdata     = mem_data_out;
          mem_address = addr_q;
          mem_rw      = RW_READ;
          addr_d      = addr_q + ADDR_STEP;
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = F_DRAIN;
        end
        F_DRAIN: begin
          f_rvalid = 1'b1;
          f_rdata  = mem_data_out;
          f_done   = 1'b1;
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end
        D_XFER: begin
          mem_address = addr_q;
          mem_rw      = rw_q;
          addr_d      = addr_q + ADDR_STEP;
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          if (rw_q == RW_WRITE) begin
            mem_enable  = 1'b1;
            mem_data_in = d_wdata;
            d_wready    = 1'b1;
            if (cnt_q <= 4'd1) begin
              d_done  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = mem_data_out;
            if (cnt_q <= 4'd1) state_d = D_DRAIN;
          end
        end
        D_DRAIN: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_data_out;
          d_done   = 1'b1;
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow the fixed or round-robin policy.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        f_req, f_gnt, f_rvalid, f_done;
  logic [31:0] f_addr, f_rdata;
  logic [1:0]  f_size;
  logic        d_req, d_rw, d_gnt, d_rvalid, d_done, d_wready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable, mem_busy;
  logic [138:0] all_out;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.data_width(32), .address_width(32)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_size(f_size), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_done(f_done),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_rw(d_rw), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done), .d_wready(d_wready),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  assign all_out = {f_gnt, f_rvalid, f_rdata, f_done, d_gnt, d_rvalid, d_rdata, d_done,
                    d_wready, mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic quiet_inputs();
    f_req = 0; f_addr = 0; f_size = 0;
    d_req = 0; d_addr = 0; d_size = 0; d_rw = 1; d_wdata = 0;
    mem_busy = 0; mem_data_out = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    quiet_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    reset = 1;
    f_req = 1; d_req = 1; f_addr = 32'h100; d_addr = 32'h200;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(negedge clock); #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_held: got %h want 0", all_out); end
    @(negedge clock);
    quiet_inputs();
    reset = 0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_idle: got %h want 0", all_out); end
  endtask

  task automatic test_single_fetch();
    @(negedge clock);
    f_req = 1; f_addr = 32'h8002_0000; f_size = 2'b00;
    #1;
    checks++;
    if ({f_gnt, d_gnt, mem_enable, mem_rw} !== 4'b1011) begin
      failures++; $display("FAIL fetch_issue: gnt/dgnt/en/rw got %b want 1011", {f_gnt, d_gnt, mem_enable, mem_rw});
    end
    checks++;
    if (mem_address !== 32'h8002_0000 || mem_access_size !== 2'b00) begin
      failures++; $display("FAIL fetch_addr: got %h/%b want 80020000/00", mem_address, mem_access_size);
    end
    @(negedge clock);
    f_req = 0; mem_data_out = 32'hCAFE_0001;
    #1;
    checks++;
    if ({f_rvalid, f_done, f_rdata} !== {2'b11, 32'hCAFE_0001}) begin
      failures++; $display("FAIL fetch_data: rv/done/data got %b%b %h want 11 cafe0001", f_rvalid, f_done, f_rdata);
    end
    @(negedge clock);
    mem_data_out = 32'h5555_5555;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL fetch_after: got %h want 0", all_out); end
  endtask

  task automatic test_write_burst();
    logic [31:0] wd;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      d_req = (k == 0); d_rw = 0; d_addr = 32'h8002_0000; d_size = 2'b01;
      wd = 32'h11 * (k + 1);
      d_wdata = wd;
      #1;
      checks++;
      if (k < 4) begin
        if ({d_wready, d_gnt, d_done, f_rvalid, mem_rw} !== {1'b1, k == 0, k == 3, 1'b0, 1'b0}
            || mem_data_in !== wd || mem_address !== 32'h8002_0000 + 32'(4 * k)) begin
          failures++;
          $display("FAIL write_beat%0d: wr/gnt/done/frv/rw %b addr %h data %h want 1%b%b00 %h %h", k,
                   {d_wready, d_gnt, d_done, f_rvalid, mem_rw}, mem_address, mem_data_in,
                   k == 0, k == 3, 32'h8002_0000 + 32'(4 * k), wd);
        end
      end else if ({d_wready, d_done, f_rvalid, mem_enable} !== 4'b0000) begin
        failures++; $display("FAIL write_end: wr/done/frv/en got %b want 0000", {d_wready, d_done, f_rvalid, mem_enable});
      end
    end
    d_rw = 1;
  endtask

  task automatic test_simultaneous();
    logic d_first;
    logic [5:0] got, exp;
    logic f_rv, d_rv;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    d_first = 0;
`else
    d_first = 1;
`endif
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      f_addr = 32'h1000; f_size = 2'b01;
      d_addr = 32'h2000; d_size = 2'b01; d_rw = 1;
      d_req = d_first ? (c == 0) : (c <= 5);
      f_req = d_first ? (c <= 5) : (c == 0);
      mem_data_out = 32'hD000_0000 + 32'(c);
      #1;
      f_rv = d_first ? (c >= 6 && c <= 9) : (c >= 1 && c <= 4);
      d_rv = d_first ? (c >= 1 && c <= 4) : (c >= 6 && c <= 9);
      exp = {d_first ? (c == 5) : (c == 0), d_first ? (c == 0) : (c == 5),
             f_rv, d_rv, f_rv && (c == 4 || c == 9), d_rv && (c == 4 || c == 9)};
      got = {f_gnt, d_gnt, f_rvalid, d_rvalid, f_done, d_done};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL simul_c%0d: fg/dg/frv/drv/fd/dd got %b want %b", c, got, exp);
      end
      checks++;
      if (f_rdata !== (f_rv ? mem_data_out : 32'h0) || d_rdata !== (d_rv ? mem_data_out : 32'h0)) begin
        failures++; $display("FAIL simul_data_c%0d: f %h d %h", c, f_rdata, d_rdata);
      end
    end
    f_req = 0; d_req = 0;
  endtask

  task automatic test_busy();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      f_req = (c <= 3); f_addr = 32'h300; f_size = 2'b00;
      d_req = 0;
      mem_busy = (c <= 2);
      mem_data_out = 32'hBEEF_0000 + 32'(c);
      #1;
      checks++;
      if ({f_gnt, mem_enable, f_rvalid, f_done} !== {c == 3, c == 3, c == 4, c == 4}) begin
        failures++; $display("FAIL busy_c%0d: gnt/en/rv/done got %b want %b", c,
                             {f_gnt, mem_enable, f_rvalid, f_done}, {c == 3, c == 3, c == 4, c == 4});
      end
      if (c == 4) begin
        checks++;
        if (f_rdata !== 32'hBEEF_0004) begin
          failures++; $display("FAIL busy_data: got %h want beef0004", f_rdata);
        end
      end
    end
    mem_busy = 0;
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      f_req = (c == 0); f_addr = 32'h500; f_size = 2'b11;
      #1;
      checks++;
      if ({f_gnt, f_rvalid, f_done} !== {c == 0, c != 0, 1'b0}) begin
        failures++; $display("FAIL long_c%0d: gnt/rv/done got %b want %b", c, {f_gnt, f_rvalid, f_done}, {c == 0, c != 0, 1'b0});
      end
    end
    @(negedge clock);
    reset = 1;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL midreset_outputs: got %h want 0", all_out); end
    @(negedge clock);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (all_out !== '0) begin failures++; $display("FAIL post_reset_c%0d: got %h want 0", c, all_out); end
      @(negedge clock);
    end
    d_req = 1; d_addr = 32'h600; d_size = 2'b00; d_rw = 1;
    #1;
    checks++;
    if ({d_gnt, f_gnt, mem_enable} !== 3'b101 || mem_address !== 32'h600) begin
      failures++; $display("FAIL post_reset_gnt: dg/fg/en %b addr %h want 101 600", {d_gnt, f_gnt, mem_enable}, mem_address);
    end
    @(negedge clock);
    d_req = 0; mem_data_out = 32'h0000_6666;
    #1;
    checks++;
    if ({d_rvalid, d_done, f_rvalid, f_done} !== 4'b1100 || d_rdata !== 32'h6666) begin
      failures++; $display("FAIL post_reset_data: flags %b data %h want 1100 6666", {d_rvalid, d_done, f_rvalid, f_done}, d_rdata);
    end
  endtask

  task automatic test_contention();
    int nf, nd;
    nf = 0; nd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      f_req = 1; f_addr = 32'h700; f_size = 2'b00;
      d_req = 1; d_addr = 32'h800; d_size = 2'b00; d_rw = 1;
      #1;
      if (f_gnt === 1'b1) nf++;
      if (d_gnt === 1'b1) nd++;
    end
    @(negedge clock);
    f_req = 0; d_req = 0;
    checks++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (nf != 25 || nd != 25) begin
      failures++; $display("FAIL rr_alternate: f_gnt %0d d_gnt %0d want 25 25", nf, nd);
    end
`else
    if (nf != 0 || nd != 50) begin
      failures++; $display("FAIL starvation: f_gnt %0d d_gnt %0d want 0 50", nf, nd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_burst();
    test_simultaneous();
    test_busy();
    test_reset_mid_burst();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and burst sequencer for the unified main memory of the MIPS core. It shares the single memory port (`address`/`data_in`/`access_size`/`rw`/`enable`/`busy`/`data_out`) between the instruction-fetch requester (F) and the load/store requester (D). It grants one requester at a time and sequences 1/4/8/16-word bursts. It also steers returned data back to the owning requester.

## Interface
- `data_width`, 32, word width in bits
- `address_width`, 32, byte-address width
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `f_req` in 1: fetch request, held until `f_gnt`
- `f_addr` in address_width: fetch start address (word-aligned)
- `f_size` in 2: burst code, 00=1, 01=4, 10=8, 11=16 words
- `f_gnt` out 1: one-cycle pulse, request accepted
- `f_rvalid` out 1: `f_rdata` valid this cycle
- `f_rdata` out data_width: fetch read word
- `f_done` out 1: pulse with last beat
- `d_req`, `d_addr`, `d_size` in: same meaning as the F-port signals, for the data port
- `d_rw` in 1: 0=write, 1=read
- `d_wdata` in data_width: write word for the current beat
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_done` out: same meaning as the F-port signals
- `d_wready` out 1: `d_wdata` consumed this cycle; requester advances to next word
- `mem_address`, `mem_data_in`, `mem_access_size`, `mem_rw`, `mem_enable` out: drive memory
- `mem_busy` in 1: memory busy with a previous access
- `mem_data_out` in data_width: memory read data

## Operation
- FSM states: IDLE, F_XFER, D_XFER, F_DRAIN, D_DRAIN.
- IDLE: an issue requires `mem_busy`=0 and at least one request.
  - Winner gets gnt in the issue cycle.
  - `mem_enable`=1, `mem_address`=addr, `mem_access_size`=size, `mem_rw` from requester. F is always read.
  - Beat counter loads N-1, where N=1/4/8/16.
  - Transition to the winner's XFER state.
- Arbitration default is fixed priority: D beats F.
- XFER write: `mem_data_in`=`d_wdata` each beat cycle, starting with the issue cycle.
  - `d_wready`=1 on each of the N beat cycles.
  - `d_done` pulses on beat N-1. Return to IDLE.
- XFER read: the counter decrements each cycle after issue. Enter DRAIN after N-1 further cycles.
- Read data: `x_rvalid`=1 and `x_rdata`=`mem_data_out` on cycles issue+1 … issue+N.
- DRAIN covers the final read beat. `x_done` pulses with that final rvalid, then return to IDLE.
- A non-owner requester never sees gnt, rvalid, wready or done.
- `mem_address` increments by 4 per beat.
- The counter is 4 bits and never wraps below 0.

## Timing
- Reset value of every output is 0. FSM goes to IDLE and the counter to 0.
- Reset mid-burst abandons the burst: no done, no further rvalid/wready.
- Read latency: first word arrives 1 cycle after gnt.
- Total read occupancy is N+1 cycles. Write occupancy is N cycles.
- There is at least one IDLE cycle between bursts. The next grant is at done+1 at the earliest.
- Simultaneous `f_req` and `d_req` in IDLE: winner by policy. Loser stays pending with no gnt.
- `mem_busy`=1 in IDLE: no issue and no gnt. Requests remain pending.
- A request deasserted before gnt is dropped without side effect.
- Requesters must hold addr/size/rw stable from req until gnt.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A 1-bit last-owner register flips priority after each granted burst.
  - Reset value of the register makes F the next preferred requester.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, D over F. F can starve under continuous D traffic.

## Structure
- Shared package `mem_pkg` holds:
  - access_size encodings and a size-to-beats function (00→1, 01→4, 10→8, 11→16).
  - rw encodings (READ=1, WRITE=0).
  - the FSM state enum.
- One natural sub-module: `mem_arb_pick`, a combinational grant selector. It takes f_req, d_req and last_owner and returns the winner. The round-robin macro affects only this sub-module.

## Test plan
- **Single fetch:** `f_req`, addr 0x80020000, size 00.
  - `f_gnt` in cycle 0; `mem_enable`=1, `mem_rw`=1.
  - `f_rvalid`/`f_done` in cycle 1 with the memory word.
- **Data write burst:** size 01, data 0x11…0x44.
  - Four consecutive `d_wready`, with `mem_address` 0x80020000…0x8002000C.
  - `d_done` on beat 4; `f_rvalid` never asserts.
- **Simultaneous requests:** both `f_req` and `d_req` for 4-word reads.
  - Fixed priority: D granted first and F at D's done+1.
  - Round-robin after reset: F granted first, then D.
- **Busy hold-off:** `mem_busy`=1 for 3 cycles with `f_req` pending.
  - No gnt until the cycle `mem_busy` falls.
  - Then gnt, and data 1 cycle later.
- **Reset mid-burst:** assert `reset` on beat 5 of a 16-word read.
  - All outputs 0 immediately; no `f_done`.
  - A new request after reset is granted normally.
- **Starvation (fixed priority only):** continuous `d_req`; `f_gnt` never asserts over 100 cycles.
